// File: rtl/win_accum_writer.sv
// Window accumulator: sums the 32 row-tagged pixel beats of each POI window and
// writes the finished sum to the result RAM at the POI address sampled on row 0.
module win_accum_writer #(
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int PIX_W     = 8,
  parameter int WIN_ROWS  = 32,
  parameter int ACC_W     = PIX_W + 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_valid,
  input  logic [PIX_W-1:0]               rd_data,
  input  logic [4:0]                     rd_row,
  input  logic [POI_DEPTH+POI_WIDTH-1:0] poi_addr,
  output logic                           in_ready,
  output logic                           wr_en,
  output logic [POI_DEPTH+POI_WIDTH-1:0] wr_addr,
  output logic [ACC_W-1:0]               wr_data,
  input  logic                           wr_ready,
  input  logic                           err_clr,
  output logic                           win_done,
  output logic                           frame_done,
  output logic                           row_err
);
  // state | meaning
  // IDLE  | waiting for the row-0 beat of a window
  // ACCUM | summing rows 1..31, exp_row holds the next expected tag
  // WRITE | holding the result until the RAM takes it
  localparam int AW = POI_DEPTH + POI_WIDTH;
  localparam logic [4:0] LAST_ROW = 5'(WIN_ROWS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, sum;
  logic [4:0]       exp_row, exp_row_nxt;
  logic [AW-1:0]    win_cnt, win_cnt_nxt;
  logic [AW-1:0]    wr_addr_nxt;
  logic [ACC_W-1:0] wr_data_nxt;
  logic             wr_en_nxt, win_done_nxt, frame_done_nxt, row_err_nxt;
  logic             accept, err_set;

  assign in_ready = (state != WRITE);
  assign accept   = rd_valid && in_ready;
  assign sum      = acc + ACC_W'(rd_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      exp_row    <= '0;
      win_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      win_done   <= 1'b0;
      frame_done <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      exp_row    <= exp_row_nxt;
      win_cnt    <= win_cnt_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      win_done   <= win_done_nxt;
      frame_done <= frame_done_nxt;
      row_err    <= row_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    exp_row_nxt    = exp_row;
    win_cnt_nxt    = win_cnt;
    wr_en_nxt      = wr_en;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    win_done_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    err_set        = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (rd_row == 5'd0) begin
            acc_nxt     = ACC_W'(rd_data);
            wr_addr_nxt = poi_addr;
            exp_row_nxt = 5'd1;
            state_nxt   = ACCUM;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (rd_row == exp_row) begin
            acc_nxt     = sum;
            exp_row_nxt = exp_row + 5'd1;
            if (rd_row == LAST_ROW) begin
              wr_data_nxt = sum;
              wr_en_nxt   = 1'b1;
              state_nxt   = WRITE;
            end
          end else begin
            // a stray row-0 tag is taken as the start of a fresh window
            err_set = 1'b1;
            if (rd_row == 5'd0) begin
              acc_nxt     = ACC_W'(rd_data);
              wr_addr_nxt = poi_addr;
              exp_row_nxt = 5'd1;
            end else begin
              acc_nxt     = '0;
              exp_row_nxt = 5'd0;
              state_nxt   = IDLE;
            end
          end
        end
      end
      WRITE: begin
        if (wr_en && wr_ready) begin
          wr_en_nxt      = 1'b0;
          win_done_nxt   = 1'b1;
          frame_done_nxt = (win_cnt == '1);
          win_cnt_nxt    = win_cnt + 1'b1;
          exp_row_nxt    = 5'd0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (err_set)      row_err_nxt = 1'b1;
    else if (err_clr) row_err_nxt = 1'b0;
    else              row_err_nxt = row_err;
  end

endmodule

// File: tb/tb_win_accum_writer.sv
// Directed bench for win_accum_writer: table of full windows plus hand-written
// error, restart, reset and frame-count sequences.
module tb_win_accum_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_data = '0;
  logic [4:0]  rd_row = '0;
  logic [7:0]  poi_addr = '0;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [12:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        err_clr = 1'b0;
  logic        win_done;
  logic        frame_done;
  logic        row_err;

  int total = 0;
  int bad = 0;

  win_accum_writer dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_row(rd_row), .poi_addr(poi_addr), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .err_clr(err_clr),
    .win_done(win_done), .frame_done(frame_done), .row_err(row_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  addr;
    int          hold;
    bit          ramp;
    bit          gap;
    logic [12:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic [4:0] r, input logic [7:0] a);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = d;
    rd_row   = r;
    poi_addr = a;
    @(posedge clk);
  endtask

  // Ends on the negedge one cycle after the win_done pulse
  task automatic run_window(input vec_t v, output logic frm);
    wr_ready = (v.hold == 0);
    for (int r = 0; r < 32; r++) begin
      // poi_addr only matters on the row-0 beat
      beat(v.ramp ? 8'(r) : v.data, 5'(r), (r == 0) ? v.addr : ~v.addr);
      if (v.gap && r < 31) begin
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
    @(negedge clk);
    rd_valid = 1'b0;
    check("wr_en_rise", wr_en, 1);
    check("wr_addr", wr_addr, v.addr);
    check("wr_data", wr_data, v.exp_data);
    check("in_ready_write", in_ready, 0);
    for (int h = 0; h < v.hold; h++) begin
      rd_valid = 1'b1;
      rd_row   = 5'd0;
      rd_data  = 8'h55;
      @(posedge clk);
      @(negedge clk);
      check("hold_wr_en", wr_en, 1);
      check("hold_wr_data", wr_data, v.exp_data);
      check("hold_wr_addr", wr_addr, v.addr);
      check("hold_in_ready", in_ready, 0);
      check("hold_win_done", win_done, 0);
    end
    wr_ready = 1'b1;
    rd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("win_done_pulse", win_done, 1);
    check("wr_en_drop", wr_en, 0);
    check("in_ready_idle", in_ready, 1);
    frm = frame_done;
    @(posedge clk);
    @(negedge clk);
    check("win_done_low", win_done, 0);
    check("frame_done_low", frame_done, 0);
  endtask

  initial begin
    logic frm;
    vec_t v;

    vecs[0] = '{data: 8'd1,   addr: 8'h00, hold: 0, ramp: 0, gap: 0, exp_data: 13'd32};
    vecs[1] = '{data: 8'd255, addr: 8'hA7, hold: 0, ramp: 0, gap: 0, exp_data: 13'd8160};
    vecs[2] = '{data: 8'd255, addr: 8'hA7, hold: 5, ramp: 0, gap: 0, exp_data: 13'd8160};
    vecs[3] = '{data: 8'd0,   addr: 8'h3C, hold: 1, ramp: 1, gap: 0, exp_data: 13'd496};
    vecs[4] = '{data: 8'd100, addr: 8'hFF, hold: 0, ramp: 0, gap: 0, exp_data: 13'd3200};
    vecs[5] = '{data: 8'd7,   addr: 8'h5A, hold: 2, ramp: 0, gap: 1, exp_data: 13'd224};

    do_reset();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_win_done", win_done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_row_err", row_err, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i], frm);
      check("vec_frame_done", frm, 0);
      check("vec_row_err", row_err, 0);
    end

    // Tag skip: rows 0..9 then row 12
    for (int r = 0; r < 10; r++) beat(8'd1, 5'(r), 8'h21);
    beat(8'd1, 5'd12, 8'h21);
    @(negedge clk);
    rd_valid = 1'b0;
    check("skip_row_err", row_err, 1);
    check("skip_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("skip_no_write", wr_en, 0);
    // In IDLE a row-10 beat must not be taken as a continuation
    beat(8'd1, 5'd10, 8'h21);
    for (int r = 11; r < 32; r++) beat(8'd1, 5'(r), 8'h21);
    @(negedge clk);
    rd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("skip_idle_no_write", wr_en, 0);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", row_err, 0);

    // Error set beats a coincident clear
    @(negedge clk);
    rd_valid = 1'b1; rd_row = 5'd3; rd_data = 8'd1; err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_valid = 1'b0; err_clr = 1'b0;
    check("set_wins", row_err, 1);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr2", row_err, 0);

    // Stray row 0 mid-window restarts the window
    for (int r = 0; r < 5; r++) beat(8'd50, 5'(r), 8'h99);
    v = '{data: 8'd3, addr: 8'h11, hold: 0, ramp: 0, gap: 0, exp_data: 13'd96};
    run_window(v, frm);
    check("restart_row_err", row_err, 1);

    // Asynchronous reset mid-window
    for (int r = 0; r < 6; r++) beat(8'd9, 5'(r), 8'h77);
    @(negedge clk);
    rd_valid = 1'b0;
    check("pre_rst_wr_addr", wr_addr, 8'h77);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_wr_addr", wr_addr, 0);
    check("async_wr_en", wr_en, 0);
    check("async_wr_data", wr_data, 0);
    check("async_row_err", row_err, 0);
    check("async_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    v = '{data: 8'd2, addr: 8'h42, hold: 0, ramp: 0, gap: 0, exp_data: 13'd64};
    run_window(v, frm);

    // Frame counting: 256 windows from reset, then a 257th
    do_reset();
    for (int w = 0; w < 257; w++) begin
      v = '{data: 8'd1, addr: 8'(w), hold: 0, ramp: 0, gap: 0, exp_data: 13'd32};
      run_window(v, frm);
      check("frame_done", frm, (w == 255) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
